// File: rtl/pc_gen.sv
// Program-counter generator: sequential/redirect/trap/return next-PC selection
// with a circular return-address stack and sticky overflow/underflow flags.
module pc_gen #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(32'h0000_0080),
    parameter int unsigned       STEP         = 4,
    parameter int unsigned       RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             call,
    input  logic             ret,
    input  logic             trap,
    output logic [WIDTH-1:0] pc_write,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             push;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    assign pc_plus       = pc_q + WIDTH'(STEP);
    assign pc_write      = pc_q;
    assign ras_empty     = (count_q == '0);
    assign ras_full      = (count_q == CNT_DEPTH);
    assign ras_overflow  = overflow_q;
    assign ras_underflow = underflow_q;

    // Trap beats stall; stall freezes everything else; redirect masks ret.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latches).
        pc_d        = pc_q;
        top_d       = top_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;

        if (trap) begin
            pc_d    = TRAP_VECTOR;
            top_d   = '0;
            count_d = '0;
        end else if (!stall) begin
            if (redirect) begin
                pc_d = redirect_pc;
                if (call) begin
                    push  = 1'b1;
                    top_d = top_q + PTR_ONE;
                    // A full stack wraps onto its oldest entry; count saturates.
                    if (ras_full) overflow_d = 1'b1;
                    else          count_d    = count_q + CNT_ONE;
                end
            end else if (ret) begin
                if (!ras_empty) begin
                    pc_d    = ras_mem[top_q];
                    top_d   = top_q - PTR_ONE;
                    count_d = count_q - CNT_ONE;
                end else begin
                    pc_d        = pc_plus;
                    underflow_d = 1'b1;
                end
            end else begin
                pc_d = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so all updates land together at the edge.
        if (!rst_n) begin
            pc_q        <= RESET_VECTOR;
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            top_q       <= top_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: stack entries are not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) ras_mem[top_d] <= pc_plus;
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized traffic,
// compared against a queue-based model of the PC/return-stack behaviour.
module tb_pc_gen;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] TRAP_VEC  = 32'h80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_write, pc_plus;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    int tests = 0;
    int fails = 0;

    pc_gen #(
        .WIDTH(WIDTH), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC),
        .STEP(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .call(call), .ret(ret), .trap(trap),
        .pc_write(pc_write), .pc_plus(pc_plus), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;

    function automatic void model_reset();
        m_pc  = RESET_VEC;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step();
        if (trap) begin
            m_pc = TRAP_VEC;
            m_ras.delete();
        end else if (stall) begin
            // hold everything
        end else if (redirect) begin
            if (call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end
            m_pc = redirect_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc  = m_pc + 32'd4;
                m_unf = 1'b1;
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc_write, m_pc);
        check({tag, ".plus"},  pc_plus, m_pc + 32'd4);
        check({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
        check({tag, ".full"},  32'(ras_full), 32'(m_ras.size() == DEPTH));
        check({tag, ".ovf"},   32'(ras_overflow), 32'(m_ovf));
        check({tag, ".unf"},   32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic set_in(input logic s, input logic rd, input logic [31:0] rpc,
                          input logic c, input logic r, input logic t);
        stall = s; redirect = rd; redirect_pc = rpc; call = c; ret = r; trap = t;
    endtask

    // Inputs are driven 1 time unit after a rising edge and sampled at the next one.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and sequential stepping: 0, 4, 8, 12.
        #2;
        do_reset("rst0");
        tick("seq1");
        check("seq1.const", pc_write, 32'h4);
        tick("seq2");
        tick("seq3");
        check("seq3.const", pc_write, 32'hC);

        // Stall holds against a pending redirect, then redirect lands.
        do_reset("rst1");
        tick("pre1");
        tick("pre2");
        set_in(1, 1, 32'h100, 0, 0, 0);
        tick("stall1");
        tick("stall2");
        check("stall.const", pc_write, 32'h8);
        set_in(0, 1, 32'h100, 0, 0, 0);
        tick("redir");
        check("redir.const", pc_write, 32'h100);
        set_in(0, 0, 0, 0, 0, 0);
        tick("redir.next");
        check("redir.next.const", pc_write, 32'h104);

        // Call and return.
        do_reset("rst2");
        set_in(0, 1, 32'h20, 0, 0, 0);
        tick("to20");
        set_in(0, 1, 32'h200, 1, 0, 0);
        tick("call");
        set_in(0, 0, 0, 0, 0, 0);
        tick("callee");
        set_in(0, 0, 0, 0, 1, 0);
        tick("ret");
        check("ret.const", pc_write, 32'h24);

        // Overflow: five calls from 0x0,0x10,0x20,0x30,0x40, then five returns.
        do_reset("rst3");
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 1, 32'(i * 16), 1, 0, 0);
            tick($sformatf("ovf.call%0d", i));
        end
        check("ovf.flag", 32'(ras_overflow), 32'h1);
        check("ovf.full", 32'(ras_full), 32'h1);
        set_in(0, 0, 0, 0, 1, 0);
        tick("pop1"); check("pop1.const", pc_write, 32'h44);
        tick("pop2"); check("pop2.const", pc_write, 32'h34);
        tick("pop3"); check("pop3.const", pc_write, 32'h24);
        tick("pop4"); check("pop4.const", pc_write, 32'h14);
        tick("pop5"); check("pop5.const", pc_write, 32'h18);
        check("unf.flag", 32'(ras_underflow), 32'h1);

        // Trap beats stall/redirect/ret with two entries stacked; sticky flags survive.
        set_in(0, 1, 32'h300, 1, 0, 0);
        tick("tcall1");
        set_in(0, 1, 32'h400, 1, 0, 0);
        tick("tcall2");
        set_in(1, 1, 32'h500, 1, 1, 1);
        tick("trap");
        check("trap.const", pc_write, 32'h80);
        check("trap.empty", 32'(ras_empty), 32'h1);

        // Wrap at the top of the address space, then asynchronous reset mid-cycle.
        do_reset("rst4");
        set_in(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        tick("wrap.top");
        set_in(0, 0, 0, 0, 0, 0);
        tick("wrap");
        check("wrap.const", pc_write, 32'h0);
        tick("wrap.next");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async.const", pc_write, RESET_VEC);
        check_all("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a stall with a pending call discards it.
        set_in(1, 1, 32'h700, 1, 0, 0);
        tick("mstall");
        do_reset("mstall.rst");
        tick("mstall.after");

        // Randomized traffic against the model, with occasional mid-cycle resets.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4)
                                              : ($urandom & 32'h0000_FFFC);
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3, tgt,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset($sformatf("rnd.rst%0d", n));
            end else begin
                tick($sformatf("rnd%0d", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the single-cycle CPU. Successor to the plain PC register.
- Holds the current PC and selects next PC from sequential, redirect (branch/jump), trap, and return-address-stack (RAS) sources.
- Adds stall, trap override, and a circular RAS for call/return.
- Feeds instruction-memory address and PC+STEP to the datapath.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0080, PC loaded on Trap (truncated to WIDTH).
- STEP, 4, sequential increment.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and RAS this cycle.
- Redirect  in  1  load RedirectPC (branch/jump taken).
- RedirectPC  in  WIDTH  redirect/call target.
- Call  in  1  push PCWrite+STEP; only meaningful with Redirect=1.
- Ret  in  1  pop RAS top into PC.
- Trap  in  1  jump to TRAP_VECTOR, flush RAS.
- PCWrite  out  WIDTH  current PC (registered).
- PCPlus  out  WIDTH  PCWrite+STEP (combinational).
- RasEmpty  out  1  RAS count == 0.
- RasFull  out  1  RAS count == RAS_DEPTH.
- RasOverflow  out  1  sticky: push occurred while full.
- RasUnderflow  out  1  sticky: Ret occurred while empty.

Behaviour:
- Reset=0, asynchronous and immediate:
  - PCWrite=RESET_VECTOR.
  - RAS count=0, top pointer=0.
  - RasOverflow=0, RasUnderflow=0.
  - Entry contents don't-care.
- Reset release: first rising CLK edge with Reset=1 applies normal update.
- Next-PC priority at each rising edge, highest first:
  1. Trap → PC=TRAP_VECTOR; RAS count=0. Overrides Stall, Redirect, Call and Ret.
  2. Stall → PC, RAS and flags unchanged. Redirect, Call and Ret are ignored (caller re-presents them).
  3. Redirect → PC=RedirectPC.
     - If Call=1, also push PCWrite+STEP.
     - Ret is ignored when Redirect=1.
  4. Ret → if count>0: PC=RAS[top], pop. If count==0: PC=PCPlus, RasUnderflow←1.
  5. Otherwise → PC=PCPlus.
- Call without Redirect is ignored (no push, PC=PCPlus).
- RAS is circular over RAS_DEPTH entries, with top pointer and count:
  - Push: top←top+1 mod RAS_DEPTH, write entry, count←min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry; RasOverflow←1; count stays RAS_DEPTH.
  - Pop: read entry[top], top←top−1 mod RAS_DEPTH, count−1.
  - Pointers wrap in both directions.
- Arithmetic: PCPlus = PCWrite+STEP modulo 2^WIDTH. All-ones region wraps to low addresses with no flag.
- Latency:
  - PCWrite changes one edge after a control input is sampled.
  - PCPlus follows PCWrite combinationally.
  - RasEmpty/RasFull reflect the registered count.
- Sticky flags clear only on Reset.
- Reset asserted mid-cycle or mid-stall: outputs go to reset values immediately; pending controls are discarded.

Test Plan:
- Reset/sequential: pulse Reset low, release, 3 edges → PCWrite 0, 4, 8, 12; RasEmpty=1.
- Stall/redirect: at PC=8 assert Stall with Redirect, RedirectPC=0x100, 2 edges → PC stays 8. Drop Stall, keep Redirect → PC=0x100, then 0x104.
- Call/return: at PC=0x20, Call+Redirect to 0x200 → PC=0x200, RasEmpty=0. Step to 0x204, then Ret → PC=0x24, RasEmpty=1.
- RAS overflow: with RAS_DEPTH=4, issue 5 calls from PCs 0x0, 0x10, 0x20, 0x30, 0x40 → RasFull=1, RasOverflow=1. Pops return 0x44, 0x34, 0x24, 0x14, then a 5th Ret gives PCPlus with RasUnderflow=1.
- Trap priority: Trap with Stall, Redirect and Ret all high and RAS holding 2 entries → PC=0x80, RasEmpty=1; flags unchanged.
- Wrap/async reset: WIDTH=32, Redirect to 0xFFFF_FFFC, one edge → PC=0. Assert Reset between edges → PCWrite=RESET_VECTOR before the next edge.
